// File: rtl/sevenseg_scan_driver.sv
// Multiplexed 7-segment scanner: a prescaler walks a digit index across NDIGITS
// anodes, decoding the captured BCD shadow register into registered outputs.
module sevenseg_scan_driver #(
  parameter int NDIGITS    = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEAD       = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int LZS        = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   digits_in,
  input  logic                   load,
  input  logic                   blank,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     an,
  output logic                   slot_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic AL = (ACTIVE_LOW != 0);
  // XOR masks: high-true patterns are flipped into the output polarity.
  localparam logic [6:0]         SEG_OFF = {7{AL}};
  localparam logic [NDIGITS-1:0] AN_OFF  = {NDIGITS{AL}};

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
  logic [6:0]             seg_q, seg_d;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic                   slot_done_q, slot_done_d;

  logic                   last_cnt;
  logic                   lit;
  logic                   zero_run;
  logic                   lz_supp;
  logic [3:0]             nib;
  logic [6:0]             glyph;
  logic [6:0]             seg_h;
  logic [NDIGITS-1:0]     an_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      slot_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      slot_done_q <= slot_done_d;
    end
  end

  // Scan timing is free-running; load and blank never disturb it.
  always_comb begin
    last_cnt = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d    = last_cnt ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (last_cnt) begin
      idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    shadow_d    = load ? digits_in : shadow_q;
    slot_done_d = last_cnt && (idx_q == IW'(NDIGITS - 1));
  end

  // Walk from the top nibble down so zero_run means "this and all higher are 0".
  always_comb begin
    nib      = 4'd0;
    lz_supp  = 1'b0;
    zero_run = 1'b1;
    an_h     = '0;
    lit      = !blank && (int'(cnt_q) >= DEAD);
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (shadow_q[4*k +: 4] == 4'd0);
      if (idx_q == IW'(k)) begin
        nib     = shadow_q[4*k +: 4];
        lz_supp = zero_run && (k != 0);
        an_h[k] = lit;
      end
    end
  end

  always_comb begin
    case (nib)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = 7'b0000000;
    endcase
    seg_h = (lit && !((LZS != 0) && lz_supp)) ? glyph : 7'b0000000;
    seg_d = seg_h ^ SEG_OFF;
    an_d  = an_h ^ AN_OFF;
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign slot_done = slot_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver: a plain instance and an LZS instance
// share stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_sevenseg_scan_driver;

  localparam int W = 40;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        load;
  logic        blank;
  logic [6:0]  seg, seg_l;
  logic [3:0]  an, an_l;
  logic        slot_done, slot_done_l;

  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [15:0] sh_m;
  logic [W-1:0] exp_q[$];

  sevenseg_scan_driver #(.NDIGITS(4), .SCAN_DIV(8), .DEAD(2), .ACTIVE_LOW(1), .LZS(0)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load), .blank(blank),
    .seg(seg), .an(an), .slot_done(slot_done)
  );

  sevenseg_scan_driver #(.NDIGITS(4), .SCAN_DIV(8), .DEAD(2), .ACTIVE_LOW(1), .LZS(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load), .blank(blank),
    .seg(seg_l), .an(an_l), .slot_done(slot_done_l)
  );

  // Clock and cycle counter (cyc = rising edges since reset release).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int c, input logic [11:0] act,
                       input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got seg/an/done %h, expected %h", name, c, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Output after rising edge n reflects slot position n-1 and the inputs before that edge.
  function automatic logic [11:0] model(input int n, input logic [15:0] sh,
                                        input logic blk, input bit lzs);
    int         s;
    int         c;
    int         ix;
    logic [6:0] g;
    logic [3:0] a;
    logic [15:0] upper;
    s = n - 1;
    c = s % 8;
    ix = (s / 8) % 4;
    g = 7'd0;
    a = 4'd0;
    if (!blk && c >= 2) begin
      a[ix] = 1'b1;
      g = glyph_of(sh[ix*4 +: 4]);
      upper = sh >> (ix * 4);
      if (lzs && ix > 0 && upper == 16'd0) g = 7'd0;
    end
    return {~g, ~a, ((s % 32) == 31)};
  endfunction

  // Driver: called at a falling edge, drives one cycle, queues expectation, returns at next falling edge.
  task automatic tick(input logic ld, input logic [15:0] d, input logic blk);
    load      = ld;
    digits_in = ld ? d : 16'($urandom);
    blank     = blk;
    exp_q.push_back({16'(cyc + 1), model(cyc + 1, sh_m, blk, 1'b0), model(cyc + 1, sh_m, blk, 1'b1)});
    if (ld) sh_m = d;
    @(negedge clk);
  endtask

  task automatic run_to(input int m);
    while ((cyc % 32) != m) tick(1'b0, 16'h0, 1'b0);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      while (exp_q.size() > 0 && int'(exp_q[0][39:24]) <= cyc) begin
        e = exp_q.pop_front();
        if (int'(e[39:24]) != cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missed_cycle: entry for cycle %0d seen at cycle %0d", e[39:24], cyc);
        end else begin
          check("main", cyc, {seg, an, slot_done}, e[23:12]);
          check("lzs", cyc, {seg_l, an_l, slot_done_l}, e[11:0]);
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    sh_m      = 16'h0;
    load      = 1'b0;
    blank     = 1'b0;
    digits_in = 16'h0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_main", 0, {seg, an, slot_done}, {7'h7F, 4'hF, 1'b0});
    check("reset_lzs", 0, {seg_l, an_l, slot_done_l}, {7'h7F, 4'hF, 1'b0});
    rst_n = 1'b1;

    // Scan order, dead time and slot_done period.
    tick(1'b1, 16'h4321, 1'b0);
    repeat (40) tick(1'b0, 16'h0, 1'b0);

    // Every nibble value through digit 0 (and LZS blanking of digits 1-3).
    for (int v = 0; v < 16; v++) begin
      tick(1'b1, 16'(v), 1'b0);
      repeat (31) tick(1'b0, 16'h0, 1'b0);
    end

    // Load coinciding with the last cycle of the digit 0 slot.
    run_to(0);
    tick(1'b1, 16'h0005, 1'b0);
    run_to(7);
    tick(1'b1, 16'h0009, 1'b0);
    repeat (40) tick(1'b0, 16'h0, 1'b0);

    // Blank for 5 cycles while digit 1 is lit; scan must keep its timing.
    run_to(10);
    repeat (5) tick(1'b0, 16'h0, 1'b1);
    repeat (10) tick(1'b0, 16'h0, 1'b0);

    // Leading-zero suppression pattern.
    tick(1'b1, 16'h0070, 1'b0);
    repeat (40) tick(1'b0, 16'h0, 1'b0);

    // Asynchronous reset while digit 2 is lit.
    run_to(19);
    @(posedge clk);
    #2;
    check("digit2_lit", cyc, {seg_l, an_l, slot_done_l}, {7'h7F, 4'b1011, 1'b0});
    rst_n = 1'b0;
    #1;
    check("async_rst_main", cyc, {seg, an, slot_done}, {7'h7F, 4'hF, 1'b0});
    check("async_rst_lzs", cyc, {seg_l, an_l, slot_done_l}, {7'h7F, 4'hF, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sh_m  = 16'h0;
    repeat (12) tick(1'b0, 16'h0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
